piradip_bit_stream_arbiter: RTL
===============================

// Module: piradip_bit_stream_arbiter
// PURPOSE
//  Shares one word->bit serializer (piradip_stream_to_bit, align input) between N AXIS word sources.
//  Round-robin grant; owner held for up to BURST words, until tlast, or until idle for TIMEOUT cycles.
//  Pulses align for one cycle at every ownership change so serializer/deserializer re-frame on word 0.
//  Sits between per-requester piradip_util_axis_manager-style sources and piradip_stream_to_bit.
// PARAMETERS
//  N        4   number of requesters (2..16)
//  WIDTH    32  word width, matches serializer WIDTH
//  BURST    4   max words per grant (>=1)
//  TIMEOUT  16  idle cycles (owner tvalid low) before grant is released (>=1)
//  IDW      $clog2(N)  width of owner index (derived, do not override)
// PORTS
//  clk       in   1        single clock, all logic posedge
//  rstn      in   1        asynchronous active-low reset
//  s_tdata   in   N*WIDTH  requester words, requester i at [i*WIDTH +: WIDTH]
//  s_tvalid  in   N        requester valid
//  s_tlast   in   N        requester end-of-packet, releases grant after that word
//  s_tready  out  N        requester ready, only owner's bit may be 1
//  m_tdata   out  WIDTH    to serializer words_in
//  m_tvalid  out  1        to serializer
//  m_tready  in   1        from serializer
//  m_tid     out  IDW      current owner index
//  align     out  1        one-cycle pulse to serializer/deserializer align
//  grant     out  N        one-hot owner, 0 when IDLE
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, owner=0, rr pointer=0 (requester 0 highest), counters=0;
//   align=0, grant=0, m_tvalid=0, s_tready=0, m_tid=0. Reset mid-burst discards the grant; no word is lost
//   because no handshake can complete while reset is held.
//  States: IDLE, ALIGN, GRANT.
//  IDLE: if |s_tvalid, pick first valid at or after rr pointer (wrap N-1 -> 0); latch owner -> ALIGN.
//  ALIGN: exactly one cycle; align=1, grant=onehot(owner), m_tvalid=0, s_tready=0 -> GRANT.
//  GRANT: combinational pass-through, zero latency:
//   m_tdata=s_tdata[owner], m_tvalid=s_tvalid[owner], s_tready[owner]=m_tready, other s_tready=0.
//   beat = m_tvalid & m_tready; word counter increments on beat.
//   Release when beat and (word counter==BURST-1 or s_tlast[owner]), or idle counter reaches TIMEOUT
//   (idle counter counts cycles with s_tvalid[owner]=0, clears on any owner tvalid).
//   On release: rr pointer=owner+1 (mod N); counters clear; if any s_tvalid (excluding none) -> pick from new
//   pointer, ALIGN; else IDLE. Same requester may be re-granted if it is the only one valid (still via ALIGN).
//  Simultaneous tlast and BURST-1 on same beat: single release. Release never occurs mid-handshake.
//  Requests arriving during ALIGN/GRANT wait; no preemption. align never asserted outside ALIGN.
//  Throughput: one bubble (ALIGN) per grant; back-to-back words within a grant at full rate.
// STRUCTURE
//  piradip_arb_pkg: state enum arb_state_t {IDLE, ALIGN, GRANT}; function rr_next(ptr,n).
//  Sub-module piradip_rr_pick #(N): combinational round-robin picker (req[N], ptr[IDW] -> valid, idx[IDW]).
//  Arbiter: FSM, owner/pointer regs, $clog2(BURST) word counter, $clog2(TIMEOUT+1) idle counter, output mux.
// TESTING
//  Bench: N=4 requesters via piradip_util_axis_manager, serializer + deserializer loopback (WIDTH=32),
//  sink via piradip_util_axis_subordinate; assertions on s_tready one-hot and align width.
//  1 Single: req2 sends A5A5A5A5 tlast -> align pulse 1 cycle, grant=0100, m_tid=2, word recovered; IDLE.
//  2 Round robin: req0..3 each 8 words 0xi000000k, BURST=4 -> order r0x4,r1x4,r2x4,r3x4,r0x4...; 8 align pulses.
//  3 tlast: req1 sends CCCCCCCC(tlast), DDDDDDDD with req3 pending -> grant switches to r3 after CCCCCCCC.
//  4 Timeout: req0 sends 1 word then stalls 20 cycles, req1 valid -> release at idle count 16, r1 granted.
//  5 Backpressure: sink deasserts ready randomly 50% -> all 64 words received in order, no duplicates.
//  6 Reset mid-burst: rstn low during r2 word 2 -> all outputs 0 same cycle; after release r0 wins first.

Source files
------------

// File: rtl/piradip_bit_stream_arbiter_pkg.sv
// Shared types and helpers for the bit-stream arbiter.
package piradip_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        GRANT
    } arb_state_t;

    // Next round-robin position after ptr, wrapping n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/piradip_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module piradip_rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [IDW:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (!valid && req[cand[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/piradip_bit_stream_arbiter.sv
// Round-robin arbiter sharing one word->bit serializer between N AXIS sources,
// with a one-cycle align bubble at every ownership change.
module piradip_bit_stream_arbiter
    import piradip_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int WIDTH   = 32,
    parameter  int BURST   = 4,
    parameter  int TIMEOUT = 16,
    localparam int IDW     = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N*WIDTH-1:0]   s_tdata,
    input  logic [N-1:0]         s_tvalid,
    input  logic [N-1:0]         s_tlast,
    output logic [N-1:0]         s_tready,
    output logic [WIDTH-1:0]     m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [IDW-1:0]       m_tid,
    output logic                 align,
    output logic [N-1:0]         grant
);

    localparam int WCW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int ICW = $clog2(TIMEOUT + 1);

    arb_state_t     state, state_next;
    logic [IDW-1:0] owner, ptr, pick_ptr, pick_idx;
    logic [WCW-1:0] word_cnt;
    logic [ICW-1:0] idle_cnt;
    logic [N-1:0]   owner_mask, pick_req;
    logic           pick_valid, load_owner;
    logic           owner_valid, owner_last, beat, release_now;
    logic [WIDTH-1:0] words [N];

    for (genvar i = 0; i < N; i++) begin : g_words
        assign words[i] = s_tdata[i*WIDTH +: WIDTH];
    end

    assign owner_mask  = {{(N-1){1'b0}}, 1'b1} << owner;
    assign owner_valid = s_tvalid[owner];
    assign owner_last  = s_tlast[owner];
    assign beat        = (state == GRANT) && owner_valid && m_tready;
    assign release_now = (beat && (owner_last || word_cnt == WCW'(BURST - 1)))
                       || ((state == GRANT) && !owner_valid && idle_cnt == ICW'(TIMEOUT - 1));

    // On release the owner's own valid belongs to the word just consumed, so it
    // is masked; a lone requester is picked up again from IDLE next cycle.
    assign pick_req = (state == GRANT) ? (s_tvalid & ~owner_mask) : s_tvalid;
    assign pick_ptr = (state == GRANT) ? IDW'(rr_next(32'(owner), N)) : ptr;
    assign m_tid    = owner;

    piradip_rr_pick #(.N(N)) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_owner = 1'b0;
        align      = 1'b0;
        grant      = '0;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        s_tready   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ALIGN;
                    load_owner = 1'b1;
                end
            end
            ALIGN: begin
                align      = 1'b1;
                grant      = owner_mask;
                state_next = GRANT;
            end
            GRANT: begin
                grant    = owner_mask;
                m_tdata  = words[owner];
                m_tvalid = owner_valid;
                s_tready = owner_mask & {N{m_tready}};
                if (release_now) begin
                    state_next = pick_valid ? ALIGN : IDLE;
                    load_owner = pick_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner <= '0;
            ptr   <= '0;
        end else begin
            if (load_owner) begin
                owner <= pick_idx;
            end
            if (state == GRANT && release_now) begin
                ptr <= pick_ptr;
            end
        end
    end

    // Counters only run while a grant is held and restart with every new owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt <= '0;
            idle_cnt <= '0;
        end else if (state != GRANT || release_now) begin
            word_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            if (beat) begin
                word_cnt <= word_cnt + WCW'(1);
            end
            idle_cnt <= owner_valid ? '0 : idle_cnt + ICW'(1);
        end
    end

endmodule
